// File: rtl/sort_32_u8_ctrl.sv
// Two-requester front end for a 32x8 parallel sort engine: gather, launch, capture, stream back.
// Optional engine-result watchdog is enabled by defining SORT_CTRL_TIMEOUT_EN.
module sort_32_u8_ctrl #(
    parameter int NUM      = 32,
    parameter int W_DATA   = 8,
    parameter int SORT_LAT = 3,
    parameter int TIMEOUT  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s0_valid,
    input  logic [W_DATA-1:0]       s0_data,
    output logic                    s0_ready,
    input  logic                    s1_valid,
    input  logic [W_DATA-1:0]       s1_data,
    output logic                    s1_ready,
    output logic                    srt_vld_in,
    output logic [NUM*W_DATA-1:0]   srt_din,
    input  logic                    srt_vld_out,
    input  logic [NUM*W_DATA-1:0]   srt_dout,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [W_DATA-1:0]       m_data,
    output logic                    m_id,
    output logic                    m_last,
    output logic                    busy,
    output logic                    err
);
    localparam int CW = $clog2(NUM);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SORT  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0]              state;
    logic [CW-1:0]           cnt;
    logic                    rr;
    logic                    grant;
    logic [NUM*W_DATA-1:0]   load_buf;
    logic [NUM*W_DATA-1:0]   res_buf;
    logic                    acc_valid;
    logic [W_DATA-1:0]       acc_data;
    logic                    last_idx;

`ifdef SORT_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]           tmo;
    logic                    err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign acc_valid = (state == LOAD) && (grant ? s1_valid : s0_valid);
    assign acc_data  = grant ? s1_data : s0_data;
    assign last_idx  = (cnt == CW'(NUM - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rr       <= 1'b0;
            grant    <= 1'b0;
            load_buf <= '0;
            res_buf  <= '0;
`ifdef SORT_CTRL_TIMEOUT_EN
            tmo      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
`ifdef SORT_CTRL_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Contention goes to the round-robin pointer; a lone requester wins outright.
                    if (s0_valid || s1_valid) begin
                        grant <= (s0_valid && s1_valid) ? rr : s1_valid;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (acc_valid) begin
                        load_buf[cnt*W_DATA +: W_DATA] <= acc_data;
                        cnt <= cnt + 1'b1;
                        if (last_idx) state <= SORT;
                    end
                end
                SORT: begin
                    state <= WAIT;
`ifdef SORT_CTRL_TIMEOUT_EN
                    tmo   <= '0;
`endif
                end
                WAIT: begin
                    if (srt_vld_out) begin
                        res_buf <= srt_dout;
                        state   <= DRAIN;
                    end
`ifdef SORT_CTRL_TIMEOUT_EN
                    else if (tmo == TW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        rr    <= ~grant;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (m_ready) begin
                        cnt <= cnt + 1'b1;
                        if (last_idx) begin
                            state <= IDLE;
                            rr    <= ~grant;
                            cnt   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is decoded from registered state, so no input-to-output path exists.
    assign s0_ready   = (state == LOAD) && !grant;
    assign s1_ready   = (state == LOAD) && grant;
    assign srt_vld_in = (state == SORT);
    assign srt_din    = load_buf;
    assign m_valid    = (state == DRAIN);
    assign m_data     = m_valid ? res_buf[cnt*W_DATA +: W_DATA] : '0;
    assign m_id       = m_valid && grant;
    assign m_last     = m_valid && last_idx;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sort_32_u8_ctrl.sv
// Self-checking bench for sort_32_u8_ctrl with a behavioural sort-engine model.
// Timeout checks are built when SORT_CTRL_TIMEOUT_EN is defined.
module tb_sort_32_u8_ctrl;
    localparam int NUM = 32;
    localparam int W   = 8;
    localparam int LAT = 3;
    localparam int TMO = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s0_valid, s1_valid, s0_ready, s1_ready;
    logic [W-1:0]     s0_data, s1_data;
    logic             srt_vld_in, srt_vld_out;
    logic [NUM*W-1:0] srt_din;
    logic [NUM*W-1:0] eng_dout = '0;
    logic             m_valid, m_ready, m_id, m_last, busy, err;
    logic [W-1:0]     m_data;

    always #5 clk = ~clk;

    sort_32_u8_ctrl #(.NUM(NUM), .W_DATA(W), .SORT_LAT(LAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .srt_vld_in(srt_vld_in), .srt_din(srt_din),
        .srt_vld_out(srt_vld_out), .srt_dout(eng_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_id(m_id), .m_last(m_last), .busy(busy), .err(err)
    );

    // Engine model: ascending sort of the launched vector, result valid LAT cycles later.
    logic [LAT-1:0] pipe = '0;
    bit             eng_en = 1'b1;

    function automatic logic [NUM*W-1:0] sort_vec(input logic [NUM*W-1:0] v);
        logic [W-1:0]     q[$];
        logic [NUM*W-1:0] r;
        for (int k = 0; k < NUM; k++) q.push_back(v[k*W +: W]);
        q.sort();
        r = '0;
        for (int k = 0; k < NUM; k++) r[k*W +: W] = q[k];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[LAT-2:0], srt_vld_in & eng_en};
        if (srt_vld_in) eng_dout <= sort_vec(srt_din);
    end
    assign srt_vld_out = pipe[LAT-1];

    int checks = 0, errors = 0;
    int cyc = 0, busy_cnt = 0, srt_pulses = 0, srt_cyc = 0, err_cnt = 0, err_cyc = 0;
    int mv_cnt = 0, jobs_done = 0, out_idx = 0, first_mv_cyc = 0, cur_id = 0;
    int vprob = 100;
    bit bp = 1'b0, job_open = 1'b0, stall_pend = 1'b0, busy_at_err = 1'b0;
    logic [W-1:0] held_d;
    logic         held_id, held_last;
    logic [W-1:0] src0[$], src1[$], acc0[$], acc1[$], exp_q[$];
    int           exp_ids[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        cyc++;
        if (busy) busy_cnt++;
        if (srt_vld_in) begin srt_pulses++; srt_cyc = cyc; end
        if (err) begin err_cnt++; err_cyc = cyc; busy_at_err = busy; end
        if (stall_pend) begin
            check("hold_valid", 32'(m_valid), 1);
            check("hold_data", 32'(m_data), 32'(held_d));
            check("hold_id", 32'(m_id), 32'(held_id));
            check("hold_last", 32'(m_last), 32'(held_last));
        end
        s0_valid = (src0.size() > 0) && ($urandom_range(99) < vprob);
        s0_data  = s0_valid ? src0[0] : 8'($urandom);
        if (s0_valid && s0_ready) acc0.push_back(src0.pop_front());
        s1_valid = (src1.size() > 0) && ($urandom_range(99) < vprob);
        s1_data  = s1_valid ? src1[0] : 8'($urandom);
        if (s1_valid && s1_ready) acc1.push_back(src1.pop_front());
        m_ready = bp ? ~m_ready : 1'b1;
        stall_pend = 1'b0;
        if (m_valid) begin
            mv_cnt++;
            if (!job_open) begin
                job_open = 1'b1;
                first_mv_cyc = cyc;
                check("job_expected", 32'(exp_ids.size() > 0), 1);
                cur_id = (exp_ids.size() > 0) ? exp_ids.pop_front() : 0;
                exp_q.delete();
                for (int k = 0; k < NUM; k++) begin
                    if (cur_id == 0 && acc0.size() > 0) exp_q.push_back(acc0.pop_front());
                    else if (cur_id == 1 && acc1.size() > 0) exp_q.push_back(acc1.pop_front());
                end
                check("job_bytes", exp_q.size(), NUM);
                exp_q.sort();
            end
            if (m_ready) begin
                check("m_data", 32'(m_data), (out_idx < exp_q.size()) ? 32'(exp_q[out_idx]) : 32'hDEAD);
                check("m_id", 32'(m_id), cur_id);
                check("m_last", 32'(m_last), 32'(out_idx == NUM - 1));
                out_idx++;
                if (out_idx == NUM) begin out_idx = 0; job_open = 1'b0; jobs_done++; end
            end else begin
                stall_pend = 1'b1;
                held_d = m_data; held_id = m_id; held_last = m_last;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_jobs(input int n, input int budget);
        int target = jobs_done + n;
        int c = 0;
        while (jobs_done < target && c < budget) begin step(); c++; end
        check("jobs_done", jobs_done, target);
    endtask

    task automatic do_reset();
        src0.delete(); src1.delete(); acc0.delete(); acc1.delete(); exp_ids.delete();
        job_open = 1'b0; out_idx = 0; stall_pend = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_s0_ready", 32'(s0_ready), 0);
        check("rst_s1_ready", 32'(s1_ready), 0);
        check("rst_srt_vld_in", 32'(srt_vld_in), 0);
        check("rst_srt_din", 32'(|srt_din), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_m_id", 32'(m_id), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
    endtask

    task automatic push_rand(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            if (id == 0) src0.push_back(8'($urandom));
            else         src1.push_back(8'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data = '0; s1_data = '0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        // Single descending job from requester 0, with turnaround timing.
        for (int i = 0; i < NUM; i++) src0.push_back(8'(NUM - 1 - i));
        exp_ids.push_back(0);
        busy_cnt = 0; srt_pulses = 0;
        run_jobs(1, 200);
        check("srt_pulses", srt_pulses, 1);
        check("busy_cycles", busy_cnt, 2*NUM + 1 + LAT);
        check("result_latency", first_mv_cyc - srt_cyc, LAT + 1);

        // Duplicates from requester 1.
        for (int i = 0; i < NUM; i++) src1.push_back((i % 2 == 0) ? 8'hFF : 8'h00);
        exp_ids.push_back(1);
        run_jobs(1, 200);

        // Arbitration from reset: 0, then 1, then 0 while requester 0 stays valid.
        do_reset();
        push_rand(0, 2*NUM);
        push_rand(1, NUM);
        exp_ids.push_back(0); exp_ids.push_back(1); exp_ids.push_back(0);
        run_jobs(3, 400);

        // Backpressure and input gaps.
        vprob = 70; bp = 1'b1;
        push_rand(0, NUM); exp_ids.push_back(0);
        run_jobs(1, 500);
        push_rand(1, NUM); exp_ids.push_back(1);
        run_jobs(1, 500);
        vprob = 100; bp = 1'b0; m_ready = 1'b1;

        // Reset after 10 accepted bytes, then a fresh job.
        push_rand(0, NUM);
        for (int c = 0; c < 100 && acc0.size() < 10; c++) step();
        check("partial_accepted", acc0.size(), 10);
        do_reset();
        push_rand(1, NUM); exp_ids.push_back(1);
        run_jobs(1, 200);

`ifdef SORT_CTRL_TIMEOUT_EN
        // Engine never answers: watchdog must abort the job.
        eng_en = 1'b0; err_cnt = 0; mv_cnt = 0; srt_cyc = 0; err_cyc = 0;
        push_rand(0, NUM);
        for (int c = 0; c < 100; c++) step();
        check("tmo_err_pulses", err_cnt, 1);
        check("tmo_err_time", err_cyc - srt_cyc, TMO + 1);
        check("tmo_busy_at_err", 32'(busy_at_err), 0);
        check("tmo_no_m_valid", mv_cnt, 0);
        check("tmo_idle_after", 32'(busy), 0);
        eng_en = 1'b1;
`else
        check("err_quiet", err_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule
